fp_unit_arbiter: RTL and testbench
==================================

// Module: fp_unit_arbiter
// PURPOSE
//  Shares one handshaked FP unit (divider or adder: a/b strobe-ack in, z strobe-ack out) among NREQ requesters.
//  Softmax divide stage: replaces one divider per lane with a single divider fed by all 2**INPUTMAX lanes.
//  Round-robin grant, one operation in flight, result returned to the winner via a one-hot valid pulse.
// PARAMETERS
//  BITWIDTH  32  operand/result width (IEEE-754 single)
//  NREQ      4   number of requesters (2**INPUTMAX in softmax)
//  IDXW      2   index width, clog2(NREQ)
// PORTS
//  Clock     in   1              clock, rising edge
//  Reset     in   1              synchronous, active-high; also drives the shared unit's reset
//  Req       in   NREQ           per-requester request; held until matching Gnt bit seen
//  OpA       in   NREQ*BITWIDTH  packed operand A, lane i at [i*BITWIDTH +: BITWIDTH]
//  OpB       in   NREQ*BITWIDTH  packed operand B, same packing
//  Gnt       out  NREQ           one-hot, 1-cycle pulse: operands of that lane captured
//  Rsp_vld   out  NREQ           one-hot, 1-cycle pulse: Rsp_data belongs to that lane
//  Rsp_data  out  BITWIDTH       result, held until next Rsp_vld
//  Rsp_idx   out  IDXW           index of last served lane, held
//  Busy      out  1              high in every state except IDLE
//  U_a/U_b   out  BITWIDTH       operands to shared unit, stable from grant until both acks
//  U_a_stb   out  1              operand A strobe
//  U_b_stb   out  1              operand B strobe
//  U_a_ack   in   1              unit accepted A
//  U_b_ack   in   1              unit accepted B
//  U_z       in   BITWIDTH       unit result
//  U_z_stb   in   1              unit result valid
//  U_z_ack   out  1              result consumed
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, round-robin pointer Ptr=0. Reset mid-operation aborts it, no Rsp_vld.
//  FSM (all outputs registered):
//   IDLE : Req==0 -> stay. Else winner w = first set Req bit at or after Ptr (wrapping at NREQ);
//          latch U_a/U_b from lane w, Gnt[w]<=1, U_a_stb<=1, U_b_stb<=1, Ptr<=(w+1)%NREQ, -> LOAD.
//   LOAD : Gnt<=0. U_x_stb&&U_x_ack -> U_x_stb<=0, independently for A and B (acks may arrive in any
//          order or same cycle). Both strobes down (registered) -> WAIT_Z.
//   WAIT_Z: U_z_stb -> U_z_ack<=1, -> ACK_Z. No timeout; waits indefinitely.
//   ACK_Z: U_z_ack high one cycle; Rsp_data<=U_z, Rsp_idx<=w, Rsp_vld[w]<=1, U_z_ack<=0, -> IDLE.
//   IDLE clears Rsp_vld (single pulse).
//  Timing: Req rises at edge t (state IDLE) -> Gnt pulse cycle t+1. With unit latency L from last
//   ack to z_stb, Rsp_vld = last ack + L + 2 cycles. Back-to-back requests: next Gnt 1 cycle after
//   Rsp_vld cycle (IDLE arbitration cycle inserted).
//  Req sampled only in IDLE; Req drop/rise in other states has no effect. Requester drops Req the
//   cycle after its Gnt; a still-high Req is treated as a new request in the next IDLE.
//  Fairness: with all Req high, grants cycle 0,1,2,...,NREQ-1,0. Single requester: always granted.
//  Operands copied at grant; lane inputs may change after Gnt without affecting the operation.
//  Spurious U_a_ack/U_b_ack/U_z_stb outside LOAD/WAIT_Z ignored. At most one Gnt/Rsp_vld bit ever set.
// STRUCTURE
//  Shared package: state encodings (IDLE/LOAD/WAIT_Z/ACK_Z), BITWIDTH default, clog2 helper.
//  Sub-module: rr_pick (combinational: Req, Ptr -> one-hot winner + index + any). Rest inline.
// TESTING
//  1 Reset, Req=0 -> Busy=0, Gnt=0, strobes 0 for 20 cycles.
//  2 Req=0001, lane0 A=3F800000 B=40000000, real divider -> Gnt=0001, Rsp_vld=0001, Rsp_data=3F000000.
//  3 Req=1111 held, lane i A=40C00000 B=40400000 -> grant order 0,1,2,3,0; each Rsp=40000000, idx matches.
//  4 Unit model: a_ack 3 cycles before b_ack, then b_ack+a_ack same cycle -> each strobe drops after own ack; Rsp once.
//  5 Ptr=2, Req=0011 -> lane0 granted first, then lane1; Req=0100 mid-op ignored until IDLE.
//  6 Reset asserted during WAIT_Z -> no Rsp_vld, Ptr=0, next Req=1000 served normally.

Source files
------------

// File: rtl/fp_unit_arbiter_pkg.sv
// Shared definitions for the FP unit arbiter: FSM encoding, default width, clog2 helper.
package fp_unit_arbiter_pkg;

    localparam int unsigned BitwidthDefault = 32;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StLoad  = 2'd1,
        StWaitZ = 2'd2,
        StAckZ  = 2'd3
    } arb_state_e;

    // Index width for n entries; never returns 0 so a single-requester build still has a port.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < n) begin
            r++;
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/fp_unit_arbiter_rr_pick.sv
// Round-robin picker: first set request at or after ptr, wrapping at NREQ.
module fp_unit_arbiter_rr_pick
    import fp_unit_arbiter_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDXW = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDXW-1:0] ptr,
    output logic [NREQ-1:0] onehot,
    output logic [IDXW-1:0] idx,
    output logic            any
);

    logic [IDXW-1:0] cand;

    // Scan lanes starting at ptr; the first hit wins and later hits are masked by any.
    always_comb begin
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        cand   = '0;
        for (int i = 0; i < int'(NREQ); i++) begin
            cand = IDXW'((int'(ptr) + i) % int'(NREQ));
            if (!any && req[cand]) begin
                any = 1'b1;
                idx = cand;
            end
        end
        if (any) begin
            onehot[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/fp_unit_arbiter.sv
// Shares one strobe/ack FP unit among NREQ requesters, one operation in flight, round-robin.
module fp_unit_arbiter
    import fp_unit_arbiter_pkg::*;
#(
    parameter int unsigned BITWIDTH = BitwidthDefault,
    parameter int unsigned NREQ     = 4,
    parameter int unsigned IDXW     = clog2(NREQ)
) (
    input  logic                     Clock,
    input  logic                     Reset,
    input  logic [NREQ-1:0]          Req,
    input  logic [NREQ*BITWIDTH-1:0] OpA,
    input  logic [NREQ*BITWIDTH-1:0] OpB,
    output logic [NREQ-1:0]          Gnt,
    output logic [NREQ-1:0]          Rsp_vld,
    output logic [BITWIDTH-1:0]      Rsp_data,
    output logic [IDXW-1:0]          Rsp_idx,
    output logic                     Busy,
    output logic [BITWIDTH-1:0]      U_a,
    output logic [BITWIDTH-1:0]      U_b,
    output logic                     U_a_stb,
    output logic                     U_b_stb,
    input  logic                     U_a_ack,
    input  logic                     U_b_ack,
    input  logic [BITWIDTH-1:0]      U_z,
    input  logic                     U_z_stb,
    output logic                     U_z_ack
);

    arb_state_e state_q, state_d;

    logic [IDXW-1:0]     ptr_q, ptr_d;
    logic [IDXW-1:0]     win_q, win_d;
    logic [NREQ-1:0]     gnt_q, gnt_d;
    logic [NREQ-1:0]     rsp_vld_q, rsp_vld_d;
    logic [BITWIDTH-1:0] rsp_data_q, rsp_data_d;
    logic [IDXW-1:0]     rsp_idx_q, rsp_idx_d;
    logic [BITWIDTH-1:0] ua_q, ua_d;
    logic [BITWIDTH-1:0] ub_q, ub_d;
    logic                a_stb_q, a_stb_d;
    logic                b_stb_q, b_stb_d;
    logic                z_ack_q, z_ack_d;

    logic [NREQ-1:0]     pick_onehot;
    logic [IDXW-1:0]     pick_idx;
    logic                pick_any;

    logic [BITWIDTH-1:0] op_a_lane [NREQ];
    logic [BITWIDTH-1:0] op_b_lane [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_lane
        assign op_a_lane[i] = OpA[i*BITWIDTH +: BITWIDTH];
        assign op_b_lane[i] = OpB[i*BITWIDTH +: BITWIDTH];
    end

    fp_unit_arbiter_rr_pick #(
        .NREQ (NREQ),
        .IDXW (IDXW)
    ) u_rr_pick (
        .req    (Req),
        .ptr    (ptr_q),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    // State and registered-output storage; synchronous reset aborts any operation in flight.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q    <= StIdle;
            ptr_q      <= '0;
            win_q      <= '0;
            gnt_q      <= '0;
            rsp_vld_q  <= '0;
            rsp_data_q <= '0;
            rsp_idx_q  <= '0;
            ua_q       <= '0;
            ub_q       <= '0;
            a_stb_q    <= 1'b0;
            b_stb_q    <= 1'b0;
            z_ack_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            win_q      <= win_d;
            gnt_q      <= gnt_d;
            rsp_vld_q  <= rsp_vld_d;
            rsp_data_q <= rsp_data_d;
            rsp_idx_q  <= rsp_idx_d;
            ua_q       <= ua_d;
            ub_q       <= ub_d;
            a_stb_q    <= a_stb_d;
            b_stb_q    <= b_stb_d;
            z_ack_q    <= z_ack_d;
        end
    end

    // Next-state: LOAD leaves only once both registered strobes have dropped.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (pick_any) state_d = StLoad;
            StLoad:  if (!a_stb_q && !b_stb_q) state_d = StWaitZ;
            StWaitZ: if (U_z_stb) state_d = StAckZ;
            StAckZ:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Next values of the registered outputs; Gnt, Rsp_vld and U_z_ack default low for 1-cycle pulses.
    always_comb begin
        ptr_d      = ptr_q;
        win_d      = win_q;
        gnt_d      = '0;
        rsp_vld_d  = '0;
        rsp_data_d = rsp_data_q;
        rsp_idx_d  = rsp_idx_q;
        ua_d       = ua_q;
        ub_d       = ub_q;
        a_stb_d    = a_stb_q;
        b_stb_d    = b_stb_q;
        z_ack_d    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (pick_any) begin
                    ua_d    = op_a_lane[pick_idx];
                    ub_d    = op_b_lane[pick_idx];
                    gnt_d   = pick_onehot;
                    win_d   = pick_idx;
                    a_stb_d = 1'b1;
                    b_stb_d = 1'b1;
                    ptr_d   = (pick_idx == IDXW'(NREQ - 1)) ? '0 : pick_idx + 1'b1;
                end
            end
            StLoad: begin
                if (a_stb_q && U_a_ack) a_stb_d = 1'b0;
                if (b_stb_q && U_b_ack) b_stb_d = 1'b0;
            end
            StWaitZ: begin
                if (U_z_stb) z_ack_d = 1'b1;
            end
            StAckZ: begin
                rsp_data_d         = U_z;
                rsp_idx_d          = win_q;
                rsp_vld_d[win_q]   = 1'b1;
            end
            default: ;
        endcase
    end

    assign Gnt      = gnt_q;
    assign Rsp_vld  = rsp_vld_q;
    assign Rsp_data = rsp_data_q;
    assign Rsp_idx  = rsp_idx_q;
    assign Busy     = (state_q != StIdle);
    assign U_a      = ua_q;
    assign U_b      = ub_q;
    assign U_a_stb  = a_stb_q;
    assign U_b_stb  = b_stb_q;
    assign U_z_ack  = z_ack_q;

endmodule

// File: tb/tb_fp_unit_arbiter.sv
// Directed bench for fp_unit_arbiter with a behavioural strobe/ack divider model.
module tb_fp_unit_arbiter;

    localparam int unsigned BW   = 32;
    localparam int unsigned NREQ = 4;
    localparam int unsigned IDXW = 2;

    logic                 Clock = 1'b0;
    logic                 Reset = 1'b1;
    logic [NREQ-1:0]      Req   = '0;
    logic [NREQ*BW-1:0]   OpA   = '0;
    logic [NREQ*BW-1:0]   OpB   = '0;
    logic [NREQ-1:0]      Gnt;
    logic [NREQ-1:0]      Rsp_vld;
    logic [BW-1:0]        Rsp_data;
    logic [IDXW-1:0]      Rsp_idx;
    logic                 Busy;
    logic [BW-1:0]        U_a;
    logic [BW-1:0]        U_b;
    logic                 U_a_stb;
    logic                 U_b_stb;
    logic                 U_a_ack = 1'b0;
    logic                 U_b_ack = 1'b0;
    logic [BW-1:0]        U_z     = '0;
    logic                 U_z_stb = 1'b0;
    logic                 U_z_ack;

    int n_checks = 0;
    int n_errors = 0;
    int rsp_cnt  = 0;
    int gnt_cnt  = 0;

    // Divider model knobs
    int a_dly = 0;
    int b_dly = 0;
    int lat   = 1;

    fp_unit_arbiter #(
        .BITWIDTH (BW),
        .NREQ     (NREQ),
        .IDXW     (IDXW)
    ) dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .Req      (Req),
        .OpA      (OpA),
        .OpB      (OpB),
        .Gnt      (Gnt),
        .Rsp_vld  (Rsp_vld),
        .Rsp_data (Rsp_data),
        .Rsp_idx  (Rsp_idx),
        .Busy     (Busy),
        .U_a      (U_a),
        .U_b      (U_b),
        .U_a_stb  (U_a_stb),
        .U_b_stb  (U_b_stb),
        .U_a_ack  (U_a_ack),
        .U_b_ack  (U_b_ack),
        .U_z      (U_z),
        .U_z_stb  (U_z_stb),
        .U_z_ack  (U_z_ack)
    );

    always #5 Clock = ~Clock;

    // Single-precision <-> real for normal numbers and zero.
    function automatic real sp2r(input logic [31:0] f);
        logic [63:0] d;
        if (f[30:0] == 31'd0) d = {f[31], 63'd0};
        else d = {f[31], 11'(int'(f[30:23]) - 127 + 1023), f[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] r2sp(input real r);
        logic [63:0] d;
        d = $realtobits(r);
        if (d[62:0] == 63'd0) return {d[63], 31'd0};
        return {d[63], 8'(int'(d[62:52]) - 1023 + 127), d[51:29]};
    endfunction

    // Divider model: acks each operand after its delay, result after lat, holds z until acked.
    int          m_st = 0;
    int          a_cnt = 0;
    int          b_cnt = 0;
    int          l_cnt = 0;
    logic        got_a = 1'b0;
    logic        got_b = 1'b0;
    logic [31:0] ma = '0;
    logic [31:0] mb = '0;

    always @(posedge Clock) begin
        if (Reset) begin
            m_st <= 0; a_cnt <= 0; b_cnt <= 0; l_cnt <= 0;
            got_a <= 1'b0; got_b <= 1'b0;
            U_a_ack <= 1'b0; U_b_ack <= 1'b0; U_z_stb <= 1'b0;
        end else begin
            U_a_ack <= 1'b0;
            U_b_ack <= 1'b0;
            case (m_st)
                0: begin
                    if (U_a_stb && !got_a) begin
                        if (a_cnt >= a_dly) begin
                            U_a_ack <= 1'b1; got_a <= 1'b1; ma <= U_a;
                        end else a_cnt <= a_cnt + 1;
                    end
                    if (U_b_stb && !got_b) begin
                        if (b_cnt >= b_dly) begin
                            U_b_ack <= 1'b1; got_b <= 1'b1; mb <= U_b;
                        end else b_cnt <= b_cnt + 1;
                    end
                    if (got_a && got_b) begin
                        m_st <= 1; l_cnt <= 0;
                    end
                end
                1: begin
                    if (l_cnt >= lat) begin
                        U_z <= r2sp(sp2r(ma) / sp2r(mb)); U_z_stb <= 1'b1; m_st <= 2;
                    end else l_cnt <= l_cnt + 1;
                end
                default: begin
                    if (U_z_ack) begin
                        U_z_stb <= 1'b0; m_st <= 0; got_a <= 1'b0; got_b <= 1'b0;
                        a_cnt <= 0; b_cnt <= 0;
                    end
                end
            endcase
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Pulse monitor: any Gnt/Rsp_vld must be one-hot.
    always @(negedge Clock) begin
        if (Gnt != '0) begin
            check_val("gnt_onehot", 32'($onehot(Gnt)), 32'd1);
            gnt_cnt++;
        end
        if (Rsp_vld != '0) begin
            check_val("rsp_onehot", 32'($onehot(Rsp_vld)), 32'd1);
            rsp_cnt++;
        end
    end

    task automatic wait_gnt(output int cycles);
        cycles = 0;
        do begin
            @(negedge Clock);
            cycles++;
        end while (Gnt == '0 && cycles < 200);
    endtask

    task automatic wait_rsp();
        int c;
        c = 0;
        do begin
            @(negedge Clock);
            c++;
        end while (Rsp_vld == '0 && c < 300);
    endtask

    task automatic check_rsp(input string tag, input int lane, input logic [31:0] data);
        check_val({tag, "_vld"}, 32'(Rsp_vld), 32'(1) << lane);
        check_val({tag, "_data"}, Rsp_data, data);
        check_val({tag, "_idx"}, 32'(Rsp_idx), 32'(lane));
    endtask

    // Lane3..0: 3/1, 8/2, 6/3, 1/2 -> 3.0, 4.0, 2.0, 0.5
    task automatic set_lanes();
        OpA = {32'h40400000, 32'h41000000, 32'h40C00000, 32'h3F800000};
        OpB = {32'h3F800000, 32'h40000000, 32'h40400000, 32'h40000000};
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        repeat (3) @(negedge Clock);
        Reset = 1'b0;
    endtask

    initial begin
        int c;
        int gap;
        int saved;

        // 1: quiet after reset
        do_reset();
        check_val("rst_rsp_data", Rsp_data, 32'd0);
        check_val("rst_rsp_idx", 32'(Rsp_idx), 32'd0);
        for (int i = 0; i < 20; i++) begin
            @(negedge Clock);
            check_val("idle_quiet", 32'({Busy, Gnt, U_a_stb, U_b_stb, Rsp_vld, U_z_ack}), 32'd0);
        end

        // 2: single divide 1.0/2.0
        set_lanes();
        Req = 4'b0001;
        wait_gnt(c);
        check_val("t2_gnt", 32'(Gnt), 32'h1);
        check_val("t2_gnt_lat", 32'(c), 32'd1);
        Req = 4'b0000;
        @(negedge Clock);
        check_val("t2_busy", 32'(Busy), 32'd1);
        wait_rsp();
        check_rsp("t2_rsp", 0, 32'h3F000000);
        @(negedge Clock);
        check_val("t2_vld_pulse", 32'(Rsp_vld), 32'd0);
        check_val("t2_data_held", Rsp_data, 32'h3F000000);

        // 3: all lanes requesting, grants rotate 0,1,2,3,0
        do_reset();
        OpA = {4{32'h40C00000}};
        OpB = {4{32'h40400000}};
        Req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_rsp();
            check_rsp("t3_rsp", k % 4, 32'h40000000);
            if (k == 4) Req = 4'b0000;
            @(negedge Clock);
            if (k < 4) check_val("t3_next_gnt", 32'(Gnt), 32'(1) << ((k + 1) % 4));
        end
        repeat (5) @(negedge Clock);
        check_val("t3_idle", 32'(Busy), 32'd0);

        // 4a: A acked three cycles before B
        set_lanes();
        a_dly = 0;
        b_dly = 3;
        saved = rsp_cnt;
        Req = 4'b0010;
        wait_gnt(c);
        Req = 4'b0000;
        c = 0;
        while (!U_a_ack && c < 50) begin
            @(negedge Clock);
            c++;
        end
        check_val("t4_a_ack_only", 32'({U_a_ack, U_b_ack}), 32'b10);
        @(negedge Clock);
        check_val("t4_a_dropped", 32'({U_a_stb, U_b_stb}), 32'b01);
        gap = 1;
        while (!U_b_ack && gap < 50) begin
            @(negedge Clock);
            gap++;
        end
        check_val("t4_ack_gap", 32'(gap), 32'd3);
        @(negedge Clock);
        check_val("t4_b_dropped", 32'({U_a_stb, U_b_stb}), 32'b00);
        wait_rsp();
        check_rsp("t4a_rsp", 1, 32'h40000000);
        repeat (5) @(negedge Clock);
        check_val("t4_rsp_once", 32'(rsp_cnt - saved), 32'd1);

        // 4b: both acks in the same cycle
        a_dly = 2;
        b_dly = 2;
        Req = 4'b0001;
        wait_gnt(c);
        Req = 4'b0000;
        c = 0;
        while (!(U_a_ack || U_b_ack) && c < 50) begin
            @(negedge Clock);
            c++;
        end
        check_val("t4_same_ack", 32'({U_a_ack, U_b_ack}), 32'b11);
        @(negedge Clock);
        check_val("t4_both_dropped", 32'({U_a_stb, U_b_stb}), 32'b00);
        wait_rsp();
        check_rsp("t4b_rsp", 0, 32'h3F000000);
        a_dly = 0;
        b_dly = 0;

        // 5: pointer at 2 wraps to lane 0; mid-op request waits for IDLE
        do_reset();
        set_lanes();
        Req = 4'b0010;
        wait_gnt(c);
        Req = 4'b0000;
        wait_rsp();
        check_rsp("t5_setup", 1, 32'h40000000);
        repeat (2) @(negedge Clock);
        saved = gnt_cnt;
        Req = 4'b0011;
        wait_gnt(c);
        check_val("t5_wrap_gnt", 32'(Gnt), 32'h1);
        Req = 4'b0010;
        OpA[31:0] = 32'h0;
        repeat (2) @(negedge Clock);
        Req = 4'b0110;
        wait_rsp();
        check_rsp("t5_lane0", 0, 32'h3F000000);
        check_val("t5_no_midop_gnt", 32'(gnt_cnt - saved), 32'd1);
        @(negedge Clock);
        check_val("t5_gnt1", 32'(Gnt), 32'h2);
        Req = 4'b0100;
        wait_rsp();
        check_rsp("t5_lane1", 1, 32'h40000000);
        wait_gnt(c);
        check_val("t5_gnt2", 32'(Gnt), 32'h4);
        Req = 4'b0000;
        wait_rsp();
        check_rsp("t5_lane2", 2, 32'h40800000);

        // 6: reset during WAIT_Z aborts, pointer returns to 0
        set_lanes();
        lat = 20;
        repeat (2) @(negedge Clock);
        Req = 4'b0001;
        wait_gnt(c);
        Req = 4'b0000;
        c = 0;
        do begin
            @(negedge Clock);
            c++;
        end while (!(Busy && !U_a_stb && !U_b_stb) && c < 50);
        repeat (3) @(negedge Clock);
        saved = rsp_cnt;
        Reset = 1'b1;
        repeat (2) @(negedge Clock);
        Reset = 1'b0;
        lat = 1;
        check_val("t6_rst_busy", 32'({Busy, U_z_ack, U_a_stb, U_b_stb}), 32'd0);
        repeat (30) @(negedge Clock);
        check_val("t6_no_rsp", 32'(rsp_cnt - saved), 32'd0);
        Req = 4'b1001;
        wait_gnt(c);
        check_val("t6_ptr0_gnt", 32'(Gnt), 32'h1);
        Req = 4'b1000;
        wait_rsp();
        check_rsp("t6_lane0", 0, 32'h3F000000);
        @(negedge Clock);
        check_val("t6_gnt3", 32'(Gnt), 32'h8);
        Req = 4'b0000;
        wait_rsp();
        check_rsp("t6_lane3", 3, 32'h40400000);

        repeat (3) @(negedge Clock);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
